control_unit: RTL
=================

# control_unit

Finite-state controller that sequences the processor's instruction cycle around the program counter. It holds the instruction register and pulses the counter's `up` input once per fetch. It decodes each 16-bit instruction and drives the register-file, data-memory and ALU control lines for one instruction at a time. It sits between instruction memory (addressed by the program counter's 5-bit `address`) and the datapath.

## Interface
- `ALU_SEL_ADD`, 3'b001: ALU select code for addition.
- `ALU_SEL_SUB`, 3'b010: ALU select code for subtraction.
- `ALU_SEL_PASS`, 3'b000: ALU select code for pass-A / idle.
- `clock`  in  1  system clock; all state changes on rising edge.
- `clear`  in  1  asynchronous, active-low reset (0 = reset).
- `instr`  in  16  instruction-memory read data at current PC address, valid combinationally.
- `pc_up`  out  1  increment strobe to program counter `up`.
- `ir_q`  out  16  instruction register contents.
- `d_addr`  out  8  data-memory address.
- `d_wr`  out  1  data-memory write enable.
- `rf_s`  out  1  register-file write-data mux: 0 = ALU result, 1 = data-memory read data.
- `rf_w_addr`  out  4  register-file write address.
- `rf_w_en`  out  1  register-file write enable.
- `rf_ra_addr`  out  4  register-file read port A address.
- `rf_rb_addr`  out  4  register-file read port B address.
- `alu_s`  out  3  ALU operation select.
- `halted`  out  1  high while in HALT.
- `state_q`  out  4  current state encoding, for debug/LED display.

## Operation
- Opcode is `ir_q[15:12]`: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT. All other opcodes execute as NOOP.
- ADD/SUB format: Ra `[11:8]`, Rb `[7:4]`, Rd `[3:0]`; RF[Rd] = RF[Ra] ± RF[Rb], arithmetic modulo datapath width.
- LOAD format: d `[11:4]`, Rd `[3:0]`; RF[Rd] = D[d].
- STORE format: d `[11:4]`, Ra `[3:0]`; D[d] = RF[Ra].
- States (`state_q` encoding): INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9.
- State transitions:
  - INIT → FETCH → DECODE.
  - DECODE → the execute state for the opcode (NOOP/LOAD_A/STORE/ADD/SUB/HALT).
  - LOAD_A → LOAD_B → FETCH.
  - NOOP, STORE, ADD, SUB → FETCH.
  - HALT → HALT until `clear` is asserted.
- Outputs are Moore-style, decoded from the registered state and `ir_q`. Any output not listed for a state is 0.
  - FETCH: `pc_up`=1; `ir_q` loads `instr` on the closing edge.
  - LOAD_A: `d_addr`=d; `rf_s`=1; `rf_w_addr`=Rd. Synchronous memory read.
  - LOAD_B: same as LOAD_A plus `rf_w_en`=1.
  - STORE: `d_addr`=d; `rf_ra_addr`=Ra; `d_wr`=1.
  - ADD: `rf_ra_addr`=Ra; `rf_rb_addr`=Rb; `rf_w_addr`=Rd; `alu_s`=ALU_SEL_ADD; `rf_s`=0; `rf_w_en`=1.
  - SUB: as ADD, with `alu_s`=ALU_SEL_SUB.
  - HALT: `halted`=1; `pc_up`=0.
- Program counter wrap (31→0) is the counter's responsibility. The controller keeps fetching without special handling.

## Timing
- Reset values (`clear`=0, applied asynchronously):
  - state INIT; `ir_q`=16'h0000.
  - all enables/strobes 0; `alu_s`=ALU_SEL_PASS; `halted`=0; `state_q`=0.
- `clear` deasserted: first rising edge moves INIT→FETCH.
- Per-instruction latency, FETCH to next FETCH:
  - NOOP/STORE/ADD/SUB: 3 cycles.
  - LOAD: 4 cycles.
- `pc_up` is high for exactly one cycle per instruction.
- `clear` asserted mid-instruction (e.g. during LOAD_A, or in the same cycle as `rf_w_en`/`d_wr`): all write enables drop immediately and no partial write is committed after reset. Operation restarts from INIT.
- HALT is terminal. `instr` changes are ignored and no outputs toggle besides `halted`=1.
- `instr` is sampled only at the FETCH edge. Changes on `instr` in any other state have no effect.

## Test plan
- Reset: `clear`=0 for 3 cycles → `state_q`=0, `ir_q`=0, all enables 0. Release → `state_q` sequence 1,2 and `pc_up` high only during state 1.
- ADD: `instr`=16'h3123 → in ADD state `rf_ra_addr`=1, `rf_rb_addr`=2, `rf_w_addr`=3, `alu_s`=3'b001, `rf_w_en`=1. Next FETCH 3 cycles after the previous one.
- LOAD: `instr`=16'h2A57 → LOAD_A then LOAD_B with `d_addr`=8'hA5, `rf_w_addr`=7, `rf_s`=1. `rf_w_en`=1 only in LOAD_B. 4-cycle instruction.
- STORE then SUB: 16'h1FF4 → `d_addr`=8'hFF, `rf_ra_addr`=4, `d_wr`=1 for one cycle. Then 16'h4456 → `alu_s`=3'b010, `rf_w_addr`=6.
- HALT and illegal opcode: 16'hE000 executes as NOOP, with no enables during NOOP. 16'h5000 → `halted`=1 and `pc_up` stays 0 for 20 cycles. `clear` pulse → returns to INIT.
- Reset mid-LOAD: assert `clear` during LOAD_A → `rf_w_en` never asserted and `state_q`=0 immediately.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: instruction-cycle sequencer for a small 16-bit processor.
// Holds the instruction register, strobes the program counter once per
// fetch, and decodes one instruction at a time into register-file,
// data-memory and ALU control lines. All control outputs are Moore-style,
// derived only from the registered state and ir_q, so an asynchronous
// clear drops every write enable in the same instant it returns to INIT.
// There is no valid/ready handshake: the controller owns the pace of the
// datapath and every strobe it drives is a single-cycle, level-true
// command that the datapath acts on at the next rising clock edge.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [15:0] instr,
  output logic        pc_up,
  output logic [15:0] ir_q,
  output logic [7:0]  d_addr,
  output logic        d_wr,
  output logic        rf_s,
  output logic [3:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [3:0]  rf_ra_addr,
  output logic [3:0]  rf_rb_addr,
  output logic [2:0]  alu_s,
  output logic        halted,
  output logic [3:0]  state_q
);

  localparam logic [2:0] ALU_SEL_PASS = 3'b000;
  localparam logic [2:0] ALU_SEL_ADD  = 3'b001;
  localparam logic [2:0] ALU_SEL_SUB  = 3'b010;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t      fsm_q;
  state_t      fsm_d;
  logic [15:0] ir_d;

  // Instruction fields; which ones matter depends on the opcode.
  logic [3:0] op_f;
  logic [3:0] ra_f;
  logic [3:0] rb_f;
  logic [3:0] rd_f;
  logic [7:0] d_f;

  assign op_f = ir_q[15:12];
  assign ra_f = ir_q[11:8];
  assign rb_f = ir_q[7:4];
  assign rd_f = ir_q[3:0];
  assign d_f  = ir_q[11:4];

  assign state_q = fsm_q;

  // State and instruction register; clear wins asynchronously.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      fsm_q <= S_INIT;
      ir_q  <= 16'h0000;
    end else begin
      fsm_q <= fsm_d;
      ir_q  <= ir_d;
    end
  end

  // Next state and instruction-register load; instr is captured only as FETCH closes.
  always_comb begin
    fsm_d = fsm_q;
    ir_d  = ir_q;
    unique case (fsm_q)
      S_INIT:   fsm_d = S_FETCH;
      S_FETCH: begin
        fsm_d = S_DECODE;
        ir_d  = instr;
      end
      S_DECODE: begin
        unique case (op_f)
          OP_STORE: fsm_d = S_STORE;
          OP_LOAD:  fsm_d = S_LOAD_A;
          OP_ADD:   fsm_d = S_ADD;
          OP_SUB:   fsm_d = S_SUB;
          OP_HALT:  fsm_d = S_HALT;
          default:  fsm_d = S_NOOP;  // OP_NOOP and every unassigned opcode
        endcase
      end
      S_LOAD_A: fsm_d = S_LOAD_B;
      S_LOAD_B: fsm_d = S_FETCH;
      S_NOOP,
      S_STORE,
      S_ADD,
      S_SUB:    fsm_d = S_FETCH;
      S_HALT:   fsm_d = S_HALT;
      default:  fsm_d = S_INIT;
    endcase
  end

  // Moore output decode from the registered state and instruction fields.
  always_comb begin
    pc_up      = 1'b0;
    d_addr     = 8'h00;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = 4'h0;
    rf_w_en    = 1'b0;
    rf_ra_addr = 4'h0;
    rf_rb_addr = 4'h0;
    alu_s      = ALU_SEL_PASS;
    halted     = 1'b0;
    unique case (fsm_q)
      S_FETCH: pc_up = 1'b1;
      S_LOAD_A: begin
        // Address is presented a cycle early because the data memory reads synchronously.
        d_addr    = d_f;
        rf_s      = 1'b1;
        rf_w_addr = rd_f;
      end
      S_LOAD_B: begin
        d_addr    = d_f;
        rf_s      = 1'b1;
        rf_w_addr = rd_f;
        rf_w_en   = 1'b1;
      end
      S_STORE: begin
        d_addr     = d_f;
        rf_ra_addr = rd_f;  // STORE keeps its source register in the low nibble
        d_wr       = 1'b1;
      end
      S_ADD: begin
        rf_ra_addr = ra_f;
        rf_rb_addr = rb_f;
        rf_w_addr  = rd_f;
        alu_s      = ALU_SEL_ADD;
        rf_w_en    = 1'b1;
      end
      S_SUB: begin
        rf_ra_addr = ra_f;
        rf_rb_addr = rb_f;
        rf_w_addr  = rd_f;
        alu_s      = ALU_SEL_SUB;
        rf_w_en    = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
